// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register offsets inside a channel window,
// CTRL bit positions and the bus address width helper.
// Optional feature macro: TIMER_BANK_CASCADE_EN (enables CTRL[3] CASCADE on channels > 0).
package timer_bank_pkg;

  // Register offsets (low two address bits)
  localparam logic [1:0] REG_VAL    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_MAX    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned CTRL_CASCADE = 3;
  localparam int unsigned CTRL_PRE_LSB = 8;

  // Address = {channel, reg[1:0]}; channel field is at least one bit wide.
  function automatic int unsigned addr_width(input int unsigned channels);
    int unsigned w;
    w = $clog2(channels) + 2;
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, VAL up-counter, CTRL and MAX registers.
// Optional feature macro: TIMER_BANK_CASCADE_EN (tick from previous channel's overflow).
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   wr_val_i/ctrl/max  single-cycle write strobes, data on wdata_i
//   casc_tick_i        overflow pulse of the previous channel
//   casc_allow_i       0 forces the CASCADE bit to read-only 0 (channel 0)
//   val_o/ctrl_o/max_o register read values
//   ie_o               interrupt enable
//   ovf_o, flag_set_o  one-cycle overflow pulse (same cycle VAL reloads to 0)
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_val_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_max_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             casc_tick_i,
  input  logic             casc_allow_i,
  output logic [WIDTH-1:0] val_o,
  output logic [WIDTH-1:0] ctrl_o,
  output logic [WIDTH-1:0] max_o,
  output logic             ie_o,
  output logic             ovf_o,
  output logic             flag_set_o
);

  logic [WIDTH-1:0]      val_q, val_d;
  logic [WIDTH-1:0]      max_q, max_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  en_q, en_d;
  logic                  oneshot_q, oneshot_d;
  logic                  ie_q, ie_d;
  logic                  use_casc;
  logic                  pre_hit;
  logic                  tick;
  logic                  match;

`ifdef TIMER_BANK_CASCADE_EN
  logic cascade_q, cascade_d;
  assign use_casc = cascade_q;
`else
  logic unused_casc;
  assign unused_casc = casc_tick_i ^ casc_allow_i;
  assign use_casc    = 1'b0;
`endif

  // Not every CTRL data bit maps to a field.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  assign pre_hit = (pcnt_q == pre_q);
  assign tick    = en_q & (use_casc ? casc_tick_i : pre_hit);
  // >= so a MAX written below the running VAL still reloads on the next tick
  assign match   = (val_q >= max_q);
  // A VAL write in the tick cycle suppresses the overflow entirely.
  assign ovf_o      = tick & match & ~wr_val_i;
  assign flag_set_o = ovf_o;

  always_comb begin
    val_d     = val_q;
    max_d     = max_q;
    pre_d     = pre_q;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    ie_d      = ie_q;
`ifdef TIMER_BANK_CASCADE_EN
    cascade_d = cascade_q;
`endif
    pcnt_d = (en_q && !pre_hit) ? pcnt_q + PRESCALE_W'(1) : '0;

    if (tick) begin
      if (match) begin
        val_d = '0;
        if (oneshot_q) en_d = 1'b0;
      end else begin
        val_d = val_q + WIDTH'(1);
      end
    end

    if (wr_val_i) val_d = wdata_i;
    if (wr_max_i) max_d = wdata_i;
    if (wr_ctrl_i) begin
      en_d      = wdata_i[CTRL_EN];
      oneshot_d = wdata_i[CTRL_ONESHOT];
      ie_d      = wdata_i[CTRL_IE];
      pre_d     = wdata_i[CTRL_PRE_LSB +: PRESCALE_W];
      pcnt_d    = '0;
`ifdef TIMER_BANK_CASCADE_EN
      cascade_d = wdata_i[CTRL_CASCADE] & casc_allow_i;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      val_q     <= '0;
      max_q     <= '0;
      pre_q     <= '0;
      pcnt_q    <= '0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      ie_q      <= 1'b0;
`ifdef TIMER_BANK_CASCADE_EN
      cascade_q <= 1'b0;
`endif
    end else begin
      val_q     <= val_d;
      max_q     <= max_d;
      pre_q     <= pre_d;
      pcnt_q    <= pcnt_d;
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      ie_q      <= ie_d;
`ifdef TIMER_BANK_CASCADE_EN
      cascade_q <= cascade_d;
`endif
    end
  end

  always_comb begin
    ctrl_o                                 = '0;
    ctrl_o[CTRL_EN]                        = en_q;
    ctrl_o[CTRL_ONESHOT]                   = oneshot_q;
    ctrl_o[CTRL_IE]                        = ie_q;
    ctrl_o[CTRL_PRE_LSB +: PRESCALE_W]     = pre_q;
`ifdef TIMER_BANK_CASCADE_EN
    ctrl_o[CTRL_CASCADE]                   = cascade_q;
`endif
  end

  assign val_o = val_q;
  assign max_o = max_q;
  assign ie_o  = ie_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer bank on a single-cycle peripheral bus.
// Optional feature macro: TIMER_BANK_CASCADE_EN (channel i>0 may tick on channel i-1 overflow).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   busAddr      {channel, reg[1:0]}; reg 3 is the global STATUS (channel field ignored)
//   busEn/busWr  access strobe / write select
//   busWrData    write data
//   busRdData    combinational read data, 0 when not reading
//   sigIntr      OR over channels of (flag & IE)
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE_W = 8,
  localparam int unsigned ADDR_W    = addr_width(CHANNELS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] busAddr,
  input  logic              busEn,
  input  logic              busWr,
  input  logic [WIDTH-1:0]  busWrData,
  output logic [WIDTH-1:0]  busRdData,
  output logic              sigIntr
);

  localparam int unsigned CH_W = ADDR_W - 2;

  logic [CH_W-1:0]     ch_sel;
  logic [1:0]          reg_sel;
  logic                wr_en;
  logic                rd_en;
  logic [CHANNELS-1:0] wr_val, wr_ctrl, wr_max;
  logic [CHANNELS-1:0] flag_set;
  logic [CHANNELS-1:0] ie;
  logic [CHANNELS-1:0] flags_q, flags_d;
  logic [WIDTH-1:0]    val_arr  [CHANNELS];
  logic [WIDTH-1:0]    ctrl_arr [CHANNELS];
  logic [WIDTH-1:0]    max_arr  [CHANNELS];

  assign ch_sel  = busAddr[ADDR_W-1:2];
  assign reg_sel = busAddr[1:0];
  assign wr_en   = busEn & busWr;
  assign rd_en   = busEn & ~busWr;

  // Per-channel write strobes; channel indices >= CHANNELS match nothing.
  always_comb begin
    wr_val  = '0;
    wr_ctrl = '0;
    wr_max  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (wr_en && (32'(ch_sel) == i)) begin
        wr_val[i]  = (reg_sel == REG_VAL);
        wr_ctrl[i] = (reg_sel == REG_CTRL);
        wr_max[i]  = (reg_sel == REG_MAX);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ovf;
    logic casc_src;

    if (i == 0) begin : g_first
      assign casc_src = 1'b0;
    end else begin : g_next
      assign casc_src = g_ch[i-1].ovf;
    end

    timer_channel #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
    ) u_chan (
      .clk_i        (clk),
      .rst_i        (rst),
      .wr_val_i     (wr_val[i]),
      .wr_ctrl_i    (wr_ctrl[i]),
      .wr_max_i     (wr_max[i]),
      .wdata_i      (busWrData),
      .casc_tick_i  (casc_src),
      .casc_allow_i ((i != 0)),
      .val_o        (val_arr[i]),
      .ctrl_o       (ctrl_arr[i]),
      .max_o        (max_arr[i]),
      .ie_o         (ie[i]),
      .ovf_o        (ovf),
      .flag_set_o   (flag_set[i])
    );
  end

  // Set has priority over write-1-to-clear so a coincident event is never lost.
  always_comb begin
    flags_d = flags_q;
    if (wr_en && (reg_sel == REG_STATUS)) flags_d = flags_q & ~busWrData[CHANNELS-1:0];
    flags_d = flags_d | flag_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  always_comb begin
    busRdData = '0;
    if (rd_en) begin
      if (reg_sel == REG_STATUS) begin
        busRdData[CHANNELS-1:0] = flags_q;
      end else begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (32'(ch_sel) == i) begin
            case (reg_sel)
              REG_VAL:  busRdData = val_arr[i];
              REG_CTRL: busRdData = ctrl_arr[i];
              REG_MAX:  busRdData = max_arr[i];
              default:  busRdData = '0;
            endcase
          end
        end
      end
    end
  end

  assign sigIntr = |(flags_q & ie);

endmodule
